// File: rtl/wb_master_pkg.sv
// Shared constants and types for the Wishbone B3 burst master.
package wb_master_pkg;

  localparam int unsigned ADDR_W = 32;
  localparam int unsigned DATA_W = 32;
  localparam int unsigned SEL_W  = 4;

  localparam logic [2:0] CTI_CLASSIC = 3'b000;
  localparam logic [2:0] CTI_INCR    = 3'b010;
  localparam logic [2:0] CTI_EOB     = 3'b111;
  localparam logic [1:0] BTE_LINEAR  = 2'b00;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_BURST = 1'b1
  } state_t;

  // Byte address to word-aligned bus address.
  function automatic logic [ADDR_W-1:0] word_align(input logic [ADDR_W-1:0] a);
    return {a[ADDR_W-1:2], 2'b00};
  endfunction

endpackage

// File: rtl/wb_wdata_buf.sv
// One-entry write data register between the upstream stream and the bus;
// refills in the same cycle its current word is acked.
module wb_wdata_buf
  import wb_master_pkg::*;
(
  input  logic              wb_clk,
  input  logic              wb_rst,
  input  logic              flush,
  input  logic              allow,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              wr_valid,
  output logic              in_ready_c,
  input  logic              consume,
  output logic [DATA_W-1:0] dat,
  output logic              full,
  output logic              full_nxt_c
);

  logic load_c;

  assign in_ready_c = allow && (!full || consume);
  assign load_c     = in_ready_c && wr_valid;

  always_comb begin
    full_nxt_c = full;
    if (flush) begin
      full_nxt_c = 1'b0;
    end else if (load_c) begin
      full_nxt_c = 1'b1;
    end else if (consume) begin
      full_nxt_c = 1'b0;
    end
  end

  always_ff @(posedge wb_clk) begin
    if (wb_rst) begin
      full <= 1'b0;
      dat  <= '0;
    end else begin
      full <= full_nxt_c;
      if (load_c && !flush) begin
        dat <= wr_data;
      end
    end
  end

endmodule

// File: rtl/wb_burst_master.sv
// Wishbone B3 master turning single DMA commands into classic or
// incrementing-burst cycles; all bus outputs come straight from flops.
module wb_burst_master
  import wb_master_pkg::*;
#(
  parameter  int unsigned MAX_BURST = 16,
  localparam int unsigned LEN_W     = $clog2(MAX_BURST + 1)
) (
  input  logic              wb_clk,
  input  logic              wb_rst,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [ADDR_W-1:0] cmd_addr,
  input  logic [LEN_W-1:0]  cmd_len,
  input  logic              cmd_we,
  input  logic [SEL_W-1:0]  cmd_sel,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              wr_valid,
  output logic              wr_ready,
  output logic [DATA_W-1:0] rd_data,
  output logic              rd_valid,
  output logic              done,
  output logic              err,
  output logic [ADDR_W-1:0] m_wb_adr_o,
  output logic [SEL_W-1:0]  m_wb_sel_o,
  output logic              m_wb_we_o,
  output logic [DATA_W-1:0] m_wb_dat_o,
  input  logic [DATA_W-1:0] m_wb_dat_i,
  output logic              m_wb_cyc_o,
  output logic              m_wb_stb_o,
  input  logic              m_wb_ack_i,
  input  logic              m_wb_err_i,
  output logic [2:0]        m_wb_cti_o,
  output logic [1:0]        m_wb_bte_o
);

  state_t            state_q, state_d;
  logic [LEN_W-1:0]  rem_q, rem_d;
  logic [LEN_W-1:0]  loads_q, loads_d;

  logic              cyc_d, stb_d, we_d;
  logic [ADDR_W-1:0] adr_d;
  logic [SEL_W-1:0]  sel_d;
  logic [2:0]        cti_d;
  logic              done_d, err_d, rd_valid_d;
  logic [DATA_W-1:0] rd_data_d;

  logic              accept_c, beat_c, bus_err_c;
  logic              buf_allow_c, buf_consume_c, buf_full, buf_full_nxt_c;

  assign cmd_ready  = (state_q == ST_IDLE) && !wb_rst;
  assign accept_c   = cmd_valid && cmd_ready;
  assign m_wb_bte_o = BTE_LINEAR;

  // Error wins over a same-cycle ack; terminations with stb low are ignored.
  assign bus_err_c     = m_wb_stb_o && m_wb_err_i;
  assign beat_c        = m_wb_stb_o && m_wb_ack_i && !m_wb_err_i;
  assign buf_consume_c = beat_c && m_wb_we_o;
  assign buf_allow_c   = (state_q == ST_BURST) && m_wb_we_o && (loads_q != '0)
                         && !bus_err_c && !wb_rst;

  wb_wdata_buf u_wdata_buf (
    .wb_clk     (wb_clk),
    .wb_rst     (wb_rst),
    .flush      (bus_err_c),
    .allow      (buf_allow_c),
    .wr_data    (wr_data),
    .wr_valid   (wr_valid),
    .in_ready_c (wr_ready),
    .consume    (buf_consume_c),
    .dat        (m_wb_dat_o),
    .full       (buf_full),
    .full_nxt_c (buf_full_nxt_c)
  );

  always_comb begin
    state_d    = state_q;
    rem_d      = rem_q;
    loads_d    = loads_q;
    cyc_d      = m_wb_cyc_o;
    we_d       = m_wb_we_o;
    adr_d      = m_wb_adr_o;
    sel_d      = m_wb_sel_o;
    cti_d      = m_wb_cti_o;
    done_d     = 1'b0;
    err_d      = 1'b0;
    rd_valid_d = 1'b0;
    rd_data_d  = rd_data;
    stb_d      = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (accept_c) begin
          if (cmd_len == '0) begin
            done_d = 1'b1;
          end else begin
            state_d = ST_BURST;
            cyc_d   = 1'b1;
            we_d    = cmd_we;
            adr_d   = word_align(cmd_addr);
            sel_d   = cmd_sel;
            rem_d   = cmd_len;
            loads_d = cmd_we ? cmd_len : '0;
            cti_d   = (cmd_len == LEN_W'(1)) ? CTI_CLASSIC : CTI_INCR;
          end
        end
      end

      ST_BURST: begin
        if (wr_ready && wr_valid) begin
          loads_d = loads_q - LEN_W'(1);
        end
        if (bus_err_c) begin
          state_d = ST_IDLE;
          cyc_d   = 1'b0;
          we_d    = 1'b0;
          err_d   = 1'b1;
        end else if (beat_c) begin
          adr_d = m_wb_adr_o + ADDR_W'(4);
          rem_d = rem_q - LEN_W'(1);
          if (!m_wb_we_o) begin
            rd_valid_d = 1'b1;
            rd_data_d  = m_wb_dat_i;
          end
          if (rem_q == LEN_W'(1)) begin
            state_d = ST_IDLE;
            cyc_d   = 1'b0;
            we_d    = 1'b0;
            done_d  = 1'b1;
          end else if (rem_q == LEN_W'(2)) begin
            cti_d = CTI_EOB;
          end
        end
      end

      default: state_d = ST_IDLE;
    endcase

    // Writes strobe only while a word is staged; reads strobe for the whole cycle.
    stb_d = cyc_d && (we_d ? buf_full_nxt_c : 1'b1);
  end

  always_ff @(posedge wb_clk) begin
    if (wb_rst) begin
      state_q    <= ST_IDLE;
      rem_q      <= '0;
      loads_q    <= '0;
      m_wb_cyc_o <= 1'b0;
      m_wb_stb_o <= 1'b0;
      m_wb_we_o  <= 1'b0;
      m_wb_adr_o <= '0;
      m_wb_sel_o <= '0;
      m_wb_cti_o <= CTI_CLASSIC;
      done       <= 1'b0;
      err        <= 1'b0;
      rd_valid   <= 1'b0;
      rd_data    <= '0;
    end else begin
      state_q    <= state_d;
      rem_q      <= rem_d;
      loads_q    <= loads_d;
      m_wb_cyc_o <= cyc_d;
      m_wb_stb_o <= stb_d;
      m_wb_we_o  <= we_d;
      m_wb_adr_o <= adr_d;
      m_wb_sel_o <= sel_d;
      m_wb_cti_o <= cti_d;
      done       <= done_d;
      err        <= err_d;
      rd_valid   <= rd_valid_d;
      rd_data    <= rd_data_d;
    end
  end

  // The staged-word flag is only consulted through its next value.
  logic unused_c;
  assign unused_c = buf_full;

endmodule
